// File: rtl/fwd_unit_n.sv
// Operand forwarding for the ID stage: youngest-producer priority, dependency stall request, registered EX-stage outputs.
// Optional stall-cycle counter enabled by defining FWD_STALL_CNT_EN.
`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

module fwd_unit_n #(
  parameter int NUM_RD  = 2,
  parameter int NUM_SRC = 3,
  parameter int DW      = 32,
  parameter int AW      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [`StallBus]       stall,
  input  logic [NUM_RD-1:0]      rd_en,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  input  logic [NUM_SRC-1:0]     src_we,
  input  logic [NUM_SRC*AW-1:0]  src_waddr,
  input  logic [NUM_SRC*DW-1:0]  src_wdata,
  input  logic [NUM_SRC-1:0]     src_ready,
  output logic [NUM_RD-1:0]      fwd_sel_r,
  output logic [NUM_RD*DW-1:0]   fwd_data_r,
  output logic                   stall_req,
  output logic [31:0]            stall_cnt
);

  logic [NUM_RD-1:0]    sel;
  logic [NUM_RD*DW-1:0] data;
  logic [NUM_RD-1:0]    pend;
  logic                 bubble;
  logic                 capture;
  logic                 unused_stall;

  assign unused_stall = ^{stall[5:4], stall[1:0]};

  // Scan oldest to youngest so the youngest matching producer overwrites the rest.
  always_comb begin
    sel  = '0;
    data = '0;
    pend = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      for (int j = NUM_SRC - 1; j >= 0; j--) begin
        if (rd_en[i] && src_we[j] &&
            (src_waddr[j*AW +: AW] == rd_addr[i*AW +: AW]) &&
            (rd_addr[i*AW +: AW] != '0)) begin
          sel[i]            = 1'b1;
          data[i*DW +: DW]  = src_wdata[j*DW +: DW];
          pend[i]           = ~src_ready[j];
        end
      end
    end
  end

  assign stall_req = |pend;
  assign bubble    = (stall[2] == `Stop) && (stall[3] == `NoStop);
  assign capture   = (stall[2] == `NoStop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_sel_r  <= '0;
      fwd_data_r <= '0;
    end else if (flush || bubble) begin
      fwd_sel_r  <= '0;
      fwd_data_r <= '0;
    end else if (capture) begin
      fwd_sel_r  <= sel;
      fwd_data_r <= data;
    end
  end

`ifdef FWD_STALL_CNT_EN
  // Saturating count of cycles lost to unready producers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_req && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_unit_n.sv
// Scoreboard bench for fwd_unit_n: driver pushes model expectations, monitor pops and compares each cycle.
`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

module tb_fwd_unit_n;

  localparam int NRD = 2;
  localparam int NSRC = 3;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [`StallBus] stall;
  logic [NRD-1:0]   rd_en;
  logic [NRD*5-1:0] rd_addr;
  logic [NSRC-1:0]  src_we;
  logic [NSRC*5-1:0] src_waddr;
  logic [NSRC*32-1:0] src_wdata;
  logic [NSRC-1:0]  src_ready;
  logic [NRD-1:0]   fwd_sel_r;
  logic [NRD*32-1:0] fwd_data_r;
  logic             stall_req;
  logic [31:0]      stall_cnt;

  logic             b_rst;
  logic [`StallBus] b_stall;
  logic [2:0]       b_rd_en;
  logic [14:0]      b_rd_addr;
  logic [3:0]       b_src_we;
  logic [19:0]      b_src_waddr;
  logic [127:0]     b_src_wdata;
  logic [3:0]       b_src_ready;
  logic [2:0]       b_fwd_sel_r;
  logic [95:0]      b_fwd_data_r;
  logic             b_stall_req;
  logic [31:0]      b_stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        exp_sr;
    logic [1:0]  exp_sel;
    logic [63:0] exp_data;
    logic [31:0] exp_cnt;
  } exp_t;
  exp_t sb[$];

  logic [1:0]  m_sel;
  logic [63:0] m_data;
  logic [31:0] m_cnt;

  fwd_unit_n #(.NUM_RD(NRD), .NUM_SRC(NSRC), .DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .rd_en(rd_en), .rd_addr(rd_addr), .src_we(src_we), .src_waddr(src_waddr),
    .src_wdata(src_wdata), .src_ready(src_ready), .fwd_sel_r(fwd_sel_r),
    .fwd_data_r(fwd_data_r), .stall_req(stall_req), .stall_cnt(stall_cnt)
  );

  fwd_unit_n #(.NUM_RD(3), .NUM_SRC(4), .DW(32), .AW(5)) dut_b (
    .clk(clk), .rst(b_rst), .flush(1'b0), .stall(b_stall),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .src_we(b_src_we), .src_waddr(b_src_waddr),
    .src_wdata(b_src_wdata), .src_ready(b_src_ready), .fwd_sel_r(b_fwd_sel_r),
    .fwd_data_r(b_fwd_data_r), .stall_req(b_stall_req), .stall_cnt(b_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: each read port takes the youngest producer writing its nonzero register.
  task automatic applyStimulus();
    exp_t it;
    logic [1:0]  c_sel;
    logic [63:0] c_data;
    logic        c_sr;
    logic [4:0]  ra;
    c_sel = '0; c_data = '0; c_sr = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*5 +: 5];
      for (int j = 0; j < NSRC; j++) begin
        if (rd_en[i] && src_we[j] && ra != 0 && src_waddr[j*5 +: 5] == ra) begin
          c_sel[i] = 1'b1;
          c_data[i*32 +: 32] = src_wdata[j*32 +: 32];
          if (!src_ready[j]) c_sr = 1'b1;
          break;
        end
      end
    end
    if (!rst) begin
      m_sel = '0; m_data = '0; m_cnt = '0;
    end else begin
`ifdef FWD_STALL_CNT_EN
      if (c_sr && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
      if (flush || (stall[2] == `Stop && stall[3] == `NoStop)) begin
        m_sel = '0; m_data = '0;
      end else if (stall[2] == `NoStop) begin
        m_sel = c_sel; m_data = c_data;
      end
    end
    it.exp_sr = c_sr; it.exp_sel = m_sel; it.exp_data = m_data; it.exp_cnt = m_cnt;
    sb.push_back(it);
  endtask

  task automatic clearInputs();
    flush = 0; stall = '0; rd_en = '0; rd_addr = '0;
    src_we = '0; src_waddr = '0; src_wdata = '0; src_ready = '1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        checkOutput("stall_req", {63'd0, stall_req}, {63'd0, it.exp_sr});
        @(posedge clk);
        #2;
        checkOutput("fwd_sel_r", {62'd0, fwd_sel_r}, {62'd0, it.exp_sel});
        checkOutput("fwd_data_r", fwd_data_r, it.exp_data);
        checkOutput("stall_cnt", {32'd0, stall_cnt}, {32'd0, it.exp_cnt});
      end
    end
  end

  initial begin
    m_sel = '0; m_data = '0; m_cnt = '0;
    rst = 0; b_rst = 0;
    clearInputs();
    b_stall = '0; b_rd_en = '0; b_rd_addr = '0; b_src_we = '0;
    b_src_waddr = '0; b_src_wdata = '0; b_src_ready = '1;

    // Reset overrides hits, flush and stall.
    cycle();
    rd_en = 2'b11; rd_addr = {5'd4, 5'd4}; src_we = 3'b001;
    src_waddr = {5'd0, 5'd0, 5'd4}; src_wdata = {32'd0, 32'd0, 32'h5555};
    applyStimulus();
    cycle(); flush = 1; stall = 6'b000100; applyStimulus();

    cycle(); rst = 1; b_rst = 1; clearInputs();
    rd_en = 2'b11; rd_addr = {5'd0, 5'd8}; src_we = 3'b011;
    src_waddr = {5'd0, 5'd8, 5'd8}; src_wdata = {32'd0, 32'h22, 32'h11};
    applyStimulus();

    // Unready EX load: bubble while stalled, then capture once ready.
    cycle(); clearInputs();
    rd_en = 2'b10; rd_addr = {5'd9, 5'd0}; src_we = 3'b101;
    src_waddr = {5'd9, 5'd0, 5'd9}; src_wdata = {32'h77, 32'd0, 32'h99};
    src_ready = 3'b110; stall = 6'b000100; applyStimulus();
    cycle(); src_ready = 3'b111; stall = '0; applyStimulus();

    cycle(); clearInputs();
    rd_en = 2'b01; src_we = 3'b001; src_wdata = {64'd0, 32'hDEAD};
    applyStimulus();

    // Hold, bubble, then hold of zero.
    cycle(); clearInputs();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd3}; src_we = 3'b010;
    src_waddr = {5'd0, 5'd3, 5'd0}; src_wdata = {32'd0, 32'h22, 32'd0};
    applyStimulus();
    cycle(); stall = 6'b001100; applyStimulus();
    cycle(); stall = 6'b000100; applyStimulus();
    cycle(); stall = 6'b001100; applyStimulus();

    // Three dependency stalls, then flush with pending stall and a hit.
    cycle(); clearInputs();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd6}; src_we = 3'b001;
    src_waddr = {5'd0, 5'd0, 5'd6}; src_wdata = {64'd0, 32'h66}; src_ready = 3'b110;
    stall = 6'b001100;
    repeat (3) begin applyStimulus(); cycle(); end
    flush = 1; stall = '0; applyStimulus();
    cycle(); flush = 0; src_ready = 3'b111; applyStimulus();

    repeat (300) begin
      cycle();
      rst = ($urandom_range(0, 39) != 0);
      flush = ($urandom_range(0, 15) == 0);
      stall = 6'($urandom);
      rd_en = 2'($urandom);
      for (int i = 0; i < NRD; i++) rd_addr[i*5 +: 5] = 5'($urandom_range(0, 3));
      src_we = 3'($urandom);
      src_ready = 3'($urandom);
      for (int j = 0; j < NSRC; j++) begin
        src_waddr[j*5 +: 5] = 5'($urandom_range(0, 3));
        src_wdata[j*32 +: 32] = $urandom;
      end
      applyStimulus();
    end

    cycle(); rst = 1; clearInputs();
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    @(posedge clk); #5;
    checkOutput("scoreboard_drain", 64'(sb.size()), 64'd0);

    // Wider configuration: only WB matches port 2.
    b_rd_en = 3'b111; b_rd_addr = {5'd12, 5'd2, 5'd1};
    b_src_we = 4'b0100; b_src_waddr = {5'd7, 5'd12, 5'd6, 5'd5};
    b_src_wdata = {32'h4444, 32'hB0B0_2222, 32'h2222, 32'h1111};
    @(posedge clk); #2;
    checkOutput("b_fwd_sel_r", {61'd0, b_fwd_sel_r}, 64'd4);
    checkOutput("b_fwd_data_r_hi", {32'd0, b_fwd_data_r[95:64]}, 64'hB0B0_2222);
    checkOutput("b_fwd_data_r_lo", b_fwd_data_r[63:0], 64'd0);
    checkOutput("b_stall_req", {63'd0, b_stall_req}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
